// File: rtl/rv64g_l1_line_xfer.sv
// L1 line transfer initiator: one refill/writeback command -> LINE_BEATS 8-byte beats on req/gnt/rvalid.
// Latency: req one cycle after accept; one beat per granted cycle; gnt stalls hold the request stable.
module rv64g_l1_line_xfer #(
    parameter  int unsigned LINE_BEATS = 8,
    localparam int unsigned BEAT_IDX_W = $clog2(LINE_BEATS)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    output logic                    ready_o,
    input  logic                    fill_req_i,
    input  logic [63:0]             fill_addr_i,
    input  logic                    wb_req_i,
    input  logic [63:0]             wb_addr_i,
    input  logic [64*LINE_BEATS-1:0] wb_line_i,
    output logic                    fill_done_o,
    output logic [64*LINE_BEATS-1:0] fill_line_o,
    output logic                    wb_done_o,
    output logic                    protocol_err_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [7:0]              mem_be_o,
    output logic [63:0]             mem_addr_o,
    output logic [63:0]             mem_wdata_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [63:0]             mem_rdata_i
);
    localparam int unsigned CNT_W = BEAT_IDX_W + 1;
    localparam int unsigned LA_W  = 64 - BEAT_IDX_W - 3;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LINE_BEATS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_WB, ST_RD} state_e;
    typedef logic [LINE_BEATS-1:0][63:0] line_t;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] iss_cnt_q, iss_cnt_d, rsp_cnt_q, rsp_cnt_d;
    logic [LA_W-1:0]  line_addr_q, line_addr_d;
    line_t            wb_line_q, wb_line_d, fill_line_q, fill_line_d;
    logic             ready_q, ready_d, mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [7:0]       mem_be_q, mem_be_d;
    logic [63:0]      mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic             fill_done_q, fill_done_d, wb_done_q, wb_done_d, perr_q, perr_d;
    logic [CNT_W-1:0] iss_inc, rsp_inc;
    logic             unused_addr_lsbs;

    assign unused_addr_lsbs = ^{fill_addr_i[BEAT_IDX_W+2:0], wb_addr_i[BEAT_IDX_W+2:0]};

    function automatic logic [63:0] beat_addr(input logic [LA_W-1:0] la, input logic [CNT_W-1:0] cnt);
        return {la, cnt[BEAT_IDX_W-1:0], 3'b000};
    endfunction

    assign iss_inc = iss_cnt_q + CNT_ONE;
    assign rsp_inc = rsp_cnt_q + CNT_ONE;

    always_comb begin
        state_d     = state_q;
        iss_cnt_d   = iss_cnt_q;
        rsp_cnt_d   = rsp_cnt_q;
        line_addr_d = line_addr_q;
        wb_line_d   = wb_line_q;
        fill_line_d = fill_line_q;
        ready_d     = ready_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        fill_done_d = 1'b0;
        wb_done_d   = 1'b0;
        perr_d      = perr_q;

        case (state_q)
            ST_IDLE: begin
                if (mem_rvalid_i) perr_d = 1'b1;
                // Writeback wins a tie; the refill requester keeps its request up.
                if (wb_req_i) begin
                    state_d     = ST_WB;
                    line_addr_d = wb_addr_i[63:BEAT_IDX_W+3];
                    wb_line_d   = wb_line_i;
                    iss_cnt_d   = '0;
                    rsp_cnt_d   = '0;
                    ready_d     = 1'b0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_be_d    = 8'hFF;
                    mem_addr_d  = beat_addr(wb_addr_i[63:BEAT_IDX_W+3], '0);
                    mem_wdata_d = wb_line_i[63:0];
                end else if (fill_req_i) begin
                    state_d     = ST_RD;
                    line_addr_d = fill_addr_i[63:BEAT_IDX_W+3];
                    iss_cnt_d   = '0;
                    rsp_cnt_d   = '0;
                    ready_d     = 1'b0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_be_d    = 8'hFF;
                    mem_addr_d  = beat_addr(fill_addr_i[63:BEAT_IDX_W+3], '0);
                end
            end
            ST_WB: begin
                if (mem_rvalid_i) perr_d = 1'b1;
                if (mem_gnt_i) begin
                    iss_cnt_d = iss_inc;
                    if (iss_inc == CNT_FULL) begin
                        state_d   = ST_IDLE;
                        ready_d   = 1'b1;
                        mem_req_d = 1'b0;
                        mem_we_d  = 1'b0;
                        mem_be_d  = 8'h00;
                        wb_done_d = 1'b1;
                    end else begin
                        mem_addr_d  = beat_addr(line_addr_q, iss_inc);
                        mem_wdata_d = wb_line_q[iss_inc[BEAT_IDX_W-1:0]];
                    end
                end
            end
            ST_RD: begin
                if (mem_req_q && mem_gnt_i) begin
                    iss_cnt_d = iss_inc;
                    if (iss_inc == CNT_FULL) begin
                        mem_req_d = 1'b0;
                        mem_be_d  = 8'h00;
                    end else begin
                        mem_addr_d = beat_addr(line_addr_q, iss_inc);
                    end
                end
                if (mem_rvalid_i) begin
                    // A response with nothing outstanding is dropped and flagged.
                    if (rsp_cnt_q == iss_cnt_q) begin
                        perr_d = 1'b1;
                    end else begin
                        fill_line_d[rsp_cnt_q[BEAT_IDX_W-1:0]] = mem_rdata_i;
                        rsp_cnt_d = rsp_inc;
                        if (rsp_inc == CNT_FULL) begin
                            state_d     = ST_IDLE;
                            ready_d     = 1'b1;
                            fill_done_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            iss_cnt_q   <= '0;
            rsp_cnt_q   <= '0;
            line_addr_q <= '0;
            wb_line_q   <= '0;
            fill_line_q <= '0;
            ready_q     <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 8'h00;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            fill_done_q <= 1'b0;
            wb_done_q   <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            iss_cnt_q   <= iss_cnt_d;
            rsp_cnt_q   <= rsp_cnt_d;
            line_addr_q <= line_addr_d;
            wb_line_q   <= wb_line_d;
            fill_line_q <= fill_line_d;
            ready_q     <= ready_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            fill_done_q <= fill_done_d;
            wb_done_q   <= wb_done_d;
            perr_q      <= perr_d;
        end
    end

    assign ready_o        = ready_q;
    assign mem_req_o      = mem_req_q;
    assign mem_we_o       = mem_we_q;
    assign mem_be_o       = mem_be_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_wdata_o    = mem_wdata_q;
    assign fill_done_o    = fill_done_q;
    assign wb_done_o      = wb_done_q;
    assign protocol_err_o = perr_q;
    assign fill_line_o    = fill_line_q;
endmodule

// File: tb/tb_rv64g_l1_line_xfer.sv
// Directed bench for rv64g_l1_line_xfer with a 2-cycle-latency memory responder model.
module tb_rv64g_l1_line_xfer;
    localparam int LB = 8;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            ready_o;
    logic            fill_req_i, wb_req_i;
    logic [63:0]     fill_addr_i, wb_addr_i;
    logic [64*LB-1:0] wb_line_i;
    logic            fill_done_o, wb_done_o, protocol_err_o;
    logic [64*LB-1:0] fill_line_o;
    logic            mem_req_o, mem_we_o;
    logic [7:0]      mem_be_o;
    logic [63:0]     mem_addr_o, mem_wdata_o;
    logic            mem_gnt_i, mem_rvalid_i;
    logic [63:0]     mem_rdata_i;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [63:0] mem [0:4095];
    logic        s1_v, s2_v, force_rv, stall_on;
    logic [63:0] s1_d, s2_d;
    int          stall_a, stall_b;

    rv64g_l1_line_xfer #(.LINE_BEATS(LB)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .ready_o(ready_o),
        .fill_req_i(fill_req_i), .fill_addr_i(fill_addr_i),
        .wb_req_i(wb_req_i), .wb_addr_i(wb_addr_i), .wb_line_i(wb_line_i),
        .fill_done_o(fill_done_o), .fill_line_o(fill_line_o), .wb_done_o(wb_done_o),
        .protocol_err_o(protocol_err_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    initial forever begin
        @(posedge clk_i);
        cyc = cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Responder: decides gnt and rvalid for the current cycle at each falling edge.
    initial begin
        s1_v = 0; s2_v = 0; s1_d = '0; s2_d = '0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                s1_v = 0; s2_v = 0;
                mem_rvalid_i = 0;
                mem_gnt_i = 1;
            end else begin
                mem_gnt_i    = !(stall_on && (cyc == stall_a || cyc == stall_b));
                mem_rvalid_i = s2_v | force_rv;
                mem_rdata_i  = force_rv ? 64'hDEAD_BEEF_DEAD_BEEF : s2_d;
                s2_v = s1_v;
                s2_d = s1_d;
                s1_v = mem_req_o && mem_gnt_i && !mem_we_o;
                s1_d = mem[mem_addr_o[14:3]];
                if (mem_req_o && mem_gnt_i && mem_we_o)
                    mem[mem_addr_o[14:3]] = mem_wdata_o;
            end
        end
    end

    // Issues one command from a sample point and follows it to completion.
    task automatic run_cmd(input bit is_wb, input logic [63:0] addr, input logic [63:0] base_val,
                           input int exp_lat, input string tag);
        int t0, k, done_cyc, pulses;
        logic [63:0] lbase;
        lbase = {addr[63:6], 6'b0};
        if (is_wb) begin
            for (int b = 0; b < LB; b++) wb_line_i[b*64 +: 64] = base_val + 64'(b);
            wb_addr_i = addr;
            wb_req_i  = 1;
        end else begin
            fill_addr_i = addr;
            fill_req_i  = 1;
        end
        t0 = cyc;
        check_eq({tag, "_ready_at_issue"}, ready_o, 1);
        @(negedge clk_i); #1;
        wb_req_i = 0; fill_req_i = 0;
        k = 0; done_cyc = -1; pulses = 0;
        for (int n = 0; n < 40; n++) begin
            if (mem_req_o) begin
                check_eq({tag, "_addr"}, mem_addr_o, lbase + 64'(8 * k));
                check_eq({tag, "_we"}, mem_we_o, is_wb);
                check_eq({tag, "_be"}, mem_be_o, 8'hFF);
                if (is_wb) check_eq({tag, "_wdata"}, mem_wdata_o, base_val + 64'(k));
                if (mem_gnt_i) k++;
            end
            if (is_wb ? wb_done_o : fill_done_o) begin
                pulses++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    check_eq({tag, "_ready_at_done"}, ready_o, 1);
                end
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
            @(negedge clk_i); #1;
        end
        check_eq({tag, "_latency"}, 64'(done_cyc - t0), 64'(exp_lat));
        check_eq({tag, "_beats"}, 64'(k), 64'(LB));
        check_eq({tag, "_pulses"}, 64'(pulses), 1);
        if (!is_wb)
            for (int b = 0; b < LB; b++)
                check_eq({tag, "_line"}, fill_line_o[b*64 +: 64], base_val + 64'(b));
    endtask

    initial begin
        int t0, k, wbc, fdc, wb_cyc, fd_cyc, rd_start;
        bit rel;
        logic [64*LB-1:0] saved;

        for (int i = 0; i < 4096; i++) mem[i] = 64'h1111_0000 + 64'(i);
        rst_ni = 0; fill_req_i = 0; wb_req_i = 0; fill_addr_i = '0; wb_addr_i = '0;
        wb_line_i = '0; force_rv = 0; stall_on = 0; stall_a = 0; stall_b = 0;
        repeat (3) @(negedge clk_i);
        #1;
        check_eq("rst_ready", ready_o, 1);
        check_eq("rst_req", mem_req_o, 0);
        check_eq("rst_we", mem_we_o, 0);
        check_eq("rst_be", mem_be_o, 0);
        check_eq("rst_addr", mem_addr_o, 0);
        check_eq("rst_wdata", mem_wdata_o, 0);
        check_eq("rst_dones", {fill_done_o, wb_done_o, protocol_err_o}, 0);
        check_eq("rst_fill_line", fill_line_o == '0, 1);
        rst_ni = 1;
        @(negedge clk_i); #1;

        run_cmd(0, 64'h1040, 64'h1111_0208, 11, "fill1");
        run_cmd(1, 64'h2000, 64'hA5A5_0000, 9, "wb1");
        run_cmd(0, 64'h2000, 64'hA5A5_0000, 11, "fill2");

        // Writeback and refill together: writeback first, held refill follows.
        for (int b = 0; b < LB; b++) wb_line_i[b*64 +: 64] = 64'hC3C3_0000 + 64'(b);
        wb_addr_i = 64'h3000; fill_addr_i = 64'h1040;
        wb_req_i = 1; fill_req_i = 1;
        t0 = cyc; wbc = 0; fdc = 0; wb_cyc = -1; fd_cyc = -1; rd_start = -1; rel = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk_i); #1;
            wb_req_i = 0;
            if (wb_done_o) begin wbc++; if (wb_cyc < 0) wb_cyc = cyc; end
            if (fill_done_o) begin fdc++; if (fd_cyc < 0) fd_cyc = cyc; end
            if (mem_req_o && !mem_we_o && rd_start < 0) rd_start = cyc;
            if (rel) fill_req_i = 0;
            if (fill_req_i && ready_o && wbc > 0) rel = 1;
        end
        fill_req_i = 0;
        check_eq("both_wb_done_cyc", 64'(wb_cyc - t0), 9);
        check_eq("both_rd_start_cyc", 64'(rd_start - t0), 10);
        check_eq("both_fill_done_cyc", 64'(fd_cyc - t0), 20);
        check_eq("both_wb_pulses", 64'(wbc), 1);
        check_eq("both_fill_pulses", 64'(fdc), 1);
        check_eq("both_line0", fill_line_o[63:0], 64'h1111_0208);
        check_eq("both_line7", fill_line_o[511:448], 64'h1111_020F);
        check_eq("both_wb_mem", mem[12'h600 + 12'd5], 64'hC3C3_0005);

        // Grant stalls on cycles T+3 and T+4.
        stall_a = cyc + 3; stall_b = cyc + 4; stall_on = 1;
        run_cmd(0, 64'h1040, 64'h1111_0208, 13, "stall");
        stall_on = 0;

        // Reset in the middle of a writeback, after three beats have been granted.
        for (int b = 0; b < LB; b++) wb_line_i[b*64 +: 64] = 64'h5A5A_0000 + 64'(b);
        wb_addr_i = 64'h4000; wb_req_i = 1;
        k = 0;
        @(negedge clk_i); #1;
        wb_req_i = 0;
        for (int n = 0; n < 20; n++) begin
            if (k == 3) break;
            if (mem_req_o && mem_gnt_i) k++;
            @(negedge clk_i); #1;
        end
        check_eq("rst_mid_beats", 64'(k), 3);
        rst_ni = 0;
        #1;
        check_eq("rst_mid_ready", ready_o, 1);
        check_eq("rst_mid_req", mem_req_o, 0);
        check_eq("rst_mid_we_be", {mem_we_o, mem_be_o}, 0);
        check_eq("rst_mid_addr", mem_addr_o, 0);
        check_eq("rst_mid_wdata", mem_wdata_o, 0);
        check_eq("rst_mid_dones", {fill_done_o, wb_done_o, protocol_err_o}, 0);
        check_eq("rst_mid_fill_line", fill_line_o == '0, 1);
        @(negedge clk_i); #1;
        rst_ni = 1;
        wbc = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk_i); #1;
            if (wb_done_o) wbc++;
        end
        check_eq("rst_mid_no_wb_done", 64'(wbc), 0);
        run_cmd(0, 64'h1040, 64'h1111_0208, 11, "after_rst");

        // Unexpected response while idle.
        check_eq("perr_clear", protocol_err_o, 0);
        saved = fill_line_o;
        force_rv = 1;
        @(negedge clk_i); #2;
        force_rv = 0;
        @(negedge clk_i); #1;
        check_eq("perr_set", protocol_err_o, 1);
        check_eq("perr_line_kept", fill_line_o == saved, 1);
        repeat (3) @(negedge clk_i);
        #1;
        check_eq("perr_sticky", protocol_err_o, 1);
        check_eq("perr_ready", ready_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
